// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with almost-full/empty thresholds, occupancy count,
// sticky overflow/underflow flags, synchronous flush and standard or FWFT read mode.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         write_en,
    input  logic [DATA_WIDTH-1:0]        write_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         read_en,
    output logic [DATA_WIDTH-1:0]        read_data,
    output logic                         read_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  write_accept;
    logic                  read_accept;

    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // Acceptance looks only at registered occupancy, so a simultaneous pop never frees a slot for a push.
    assign write_accept = write_en && !full && !flush;
    assign read_accept  = read_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (write_accept) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_accept) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (read_accept) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            case ({write_accept, read_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign read_data  = mem[rd_ptr];
            assign read_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] read_data_q;
            logic                  read_valid_q;

            // read_data holds across idle cycles and flush; only reset clears it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    read_data_q  <= '0;
                    read_valid_q <= 1'b0;
                end else if (flush) begin
                    read_valid_q <= 1'b0;
                end else begin
                    read_valid_q <= read_accept;
                    if (read_accept) begin
                        read_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign read_data  = read_data_q;
            assign read_valid = read_valid_q;
        end
    endgenerate

endmodule
